// File: rtl/nileswan_pkg.sv
// Shared constants for the cartridge interrupt block: register map, status bit
// positions and timer FSM states. Honours CART_IRQ_TIMER_EN for the valid IRQ bit mask.
package nileswan_pkg;

  localparam logic [7:0] ADDR_IRQ_ENABLE   = 8'hE6;
  localparam logic [7:0] ADDR_IRQ_STATUS   = 8'hE7;
  localparam logic [7:0] ADDR_TIMER_LO     = 8'hE8;
  localparam logic [7:0] ADDR_TIMER_HI     = 8'hE9;
  localparam logic [7:0] ADDR_TIMER_CTRL   = 8'hEA;
  localparam logic [7:0] ADDR_TIMER_CNT_LO = 8'hEB;
  localparam logic [7:0] ADDR_TIMER_CNT_HI = 8'hEC;

  localparam int IRQ_W        = 3;
  localparam int IRQ_SPI_DONE = 0;
  localparam int IRQ_TIMER    = 1;
  localparam int IRQ_MCU      = 2;

`ifdef CART_IRQ_TIMER_EN
  localparam logic [IRQ_W-1:0] IRQ_MASK = 3'b111;
`else
  localparam logic [IRQ_W-1:0] IRQ_MASK = 3'b101;
`endif

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_t;

  function automatic logic [7:0] irq_byte(input logic [IRQ_W-1:0] v);
    return {{(8 - IRQ_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/irq_timer.sv
// Prescaled 16-bit down-counter with IDLE/RUN control and a one-cycle underflow
// pulse. The prescaler wraps every 256 clocks and is cleared when the timer starts.
module irq_timer
  import nileswan_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lo_wr,
  input  logic        i_hi_wr,
  input  logic        i_ctrl_wr,
  input  logic [7:0]  i_wdata,
  output logic [15:0] o_reload,
  output logic [15:0] o_count,
  output logic [1:0]  o_ctrl,
  output logic        o_underflow
);

  logic [7:0]  r_pre;
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic        r_auto;
  logic        r_underflow;
  tmr_state_t  r_state;
  logic        w_tick;

  assign w_tick = (r_pre == 8'hFF);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre       <= 8'h00;
      r_reload    <= 16'h0000;
      r_count     <= 16'h0000;
      r_auto      <= 1'b0;
      r_underflow <= 1'b0;
      r_state     <= TMR_IDLE;
    end else begin
      r_underflow <= 1'b0;
      r_pre       <= r_pre + 8'd1;
      if (i_lo_wr) r_reload[7:0]  <= i_wdata;
      if (i_hi_wr) r_reload[15:8] <= i_wdata;
      if (i_ctrl_wr) begin
        r_auto <= i_wdata[1];
        if (i_wdata[0]) begin
          r_count <= r_reload;
          r_pre   <= 8'h00;
          r_state <= TMR_RUN;
        end else begin
          r_state <= TMR_IDLE;
        end
      end else if (r_state == TMR_RUN && w_tick) begin
        // Terminal count is 1 so that reload 0 runs the full 65536 ticks via the 0->FFFF wrap
        if (r_count == 16'd1) begin
          r_underflow <= 1'b1;
          if (r_auto) begin
            r_count <= r_reload;
          end else begin
            r_count <= 16'h0000;
            r_state <= TMR_IDLE;
          end
        end else begin
          r_count <= r_count - 16'd1;
        end
      end
    end
  end

  assign o_reload    = r_reload;
  assign o_count     = r_count;
  assign o_ctrl      = {r_auto, (r_state == TMR_RUN)};
  assign o_underflow = r_underflow;

endmodule

// File: rtl/cart_irq_ctrl.sv
// Cartridge interrupt controller: SPI-done / timer / MCU status with W1C, enable mask
// and a registered active-low interrupt. Define CART_IRQ_TIMER_EN to build the timer.
module cart_irq_ctrl
  import nileswan_pkg::*;
(
  input  logic       FastClk,
  input  logic       Reset,
  input  logic       RegWrite,
  input  logic [7:0] RegAddr,
  input  logic [7:0] WriteData,
  output logic [7:0] RegOut,
  output logic       RegAck,
  input  logic       SpiBusy,
  input  logic       McuReq,
  output logic       nCartInt
);

  logic [IRQ_W-1:0] r_enable;
  logic [IRQ_W-1:0] r_status;
  logic             r_spi_prev;
  logic             r_mcu_prev;
  logic             r_nint;

  logic             w_en_wr;
  logic             w_st_wr;
  logic [IRQ_W-1:0] w_w1c;
  logic [IRQ_W-1:0] w_events;
  logic             w_underflow;

  assign w_en_wr = RegWrite && (RegAddr == ADDR_IRQ_ENABLE);
  assign w_st_wr = RegWrite && (RegAddr == ADDR_IRQ_STATUS);
  assign w_w1c   = w_st_wr ? WriteData[IRQ_W-1:0] : '0;

`ifdef CART_IRQ_TIMER_EN
  logic [15:0] w_reload;
  logic [15:0] w_count;
  logic [1:0]  w_ctrl;

  irq_timer u_timer (
    .i_clk       (FastClk),
    .i_rst       (Reset),
    .i_lo_wr     (RegWrite && (RegAddr == ADDR_TIMER_LO)),
    .i_hi_wr     (RegWrite && (RegAddr == ADDR_TIMER_HI)),
    .i_ctrl_wr   (RegWrite && (RegAddr == ADDR_TIMER_CTRL)),
    .i_wdata     (WriteData),
    .o_reload    (w_reload),
    .o_count     (w_count),
    .o_ctrl      (w_ctrl),
    .o_underflow (w_underflow)
  );
`else
  logic w_unused_wdata;
  assign w_unused_wdata = ^WriteData[7:IRQ_W];
  assign w_underflow    = 1'b0;
`endif

  always_comb begin
    w_events               = '0;
    w_events[IRQ_SPI_DONE] = r_spi_prev & ~SpiBusy;
    w_events[IRQ_TIMER]    = w_underflow;
    w_events[IRQ_MCU]      = ~r_mcu_prev & McuReq;
  end

  always_ff @(posedge FastClk) begin
    if (Reset) begin
      r_enable   <= '0;
      r_status   <= '0;
      r_spi_prev <= 1'b0;
      r_mcu_prev <= 1'b1;
      r_nint     <= 1'b1;
    end else begin
      r_spi_prev <= SpiBusy;
      r_mcu_prev <= McuReq;
      if (w_en_wr) r_enable <= WriteData[IRQ_W-1:0] & IRQ_MASK;
      // An event in the same cycle as its W1C wins: clear first, then OR in events
      r_status   <= ((r_status & ~w_w1c) | w_events) & IRQ_MASK;
      r_nint     <= ~|(r_status & r_enable);
    end
  end

  assign nCartInt = r_nint;

  always_comb begin
    RegOut = 8'h00;
    RegAck = 1'b0;
    case (RegAddr)
      ADDR_IRQ_ENABLE: begin RegAck = 1'b1; RegOut = irq_byte(r_enable); end
      ADDR_IRQ_STATUS: begin RegAck = 1'b1; RegOut = irq_byte(r_status); end
`ifdef CART_IRQ_TIMER_EN
      ADDR_TIMER_LO:     begin RegAck = 1'b1; RegOut = w_reload[7:0];   end
      ADDR_TIMER_HI:     begin RegAck = 1'b1; RegOut = w_reload[15:8];  end
      ADDR_TIMER_CTRL:   begin RegAck = 1'b1; RegOut = {6'b0, w_ctrl};  end
      ADDR_TIMER_CNT_LO: begin RegAck = 1'b1; RegOut = w_count[7:0];    end
      ADDR_TIMER_CNT_HI: begin RegAck = 1'b1; RegOut = w_count[15:8];   end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cart_irq_ctrl.sv
// Scoreboard bench for cart_irq_ctrl: a behavioural model predicts every cycle's
// read data, ack and interrupt; a monitor compares them mid-cycle. Honours CART_IRQ_TIMER_EN.
module tb_cart_irq_ctrl;

`ifdef CART_IRQ_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic       FastClk = 1'b0;
  logic       Reset = 1'b1;
  logic       RegWrite = 1'b0;
  logic [7:0] RegAddr = 8'hE6;
  logic [7:0] WriteData = 8'h00;
  logic       SpiBusy = 1'b0;
  logic       McuReq = 1'b0;
  logic [7:0] RegOut;
  logic       RegAck;
  logic       nCartInt;

  cart_irq_ctrl dut (
    .FastClk   (FastClk),
    .Reset     (Reset),
    .RegWrite  (RegWrite),
    .RegAddr   (RegAddr),
    .WriteData (WriteData),
    .RegOut    (RegOut),
    .RegAck    (RegAck),
    .SpiBusy   (SpiBusy),
    .McuReq    (McuReq),
    .nCartInt  (nCartInt)
  );

  always #5 FastClk = ~FastClk;

  typedef struct {
    logic       ack;
    logic [7:0] rd;
    logic       nint;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Behavioural model state
  bit m_valid = 1'b0;
  int m_en, m_st, m_nint, m_spi_prev, m_mcu_prev;
  int m_rel, m_cnt, m_pre, m_run, m_auto, m_uf;

  function automatic void m_read(input logic [7:0] a, output logic ack, output logic [7:0] rd);
    ack = 1'b0;
    rd  = 8'h00;
    if (a == 8'hE6) begin ack = 1'b1; rd = 8'(m_en); end
    else if (a == 8'hE7) begin ack = 1'b1; rd = 8'(m_st); end
    else if (TMR && a == 8'hE8) begin ack = 1'b1; rd = 8'(m_rel % 256); end
    else if (TMR && a == 8'hE9) begin ack = 1'b1; rd = 8'(m_rel / 256); end
    else if (TMR && a == 8'hEA) begin ack = 1'b1; rd = 8'(m_auto * 2 + m_run); end
    else if (TMR && a == 8'hEB) begin ack = 1'b1; rd = 8'(m_cnt % 256); end
    else if (TMR && a == 8'hEC) begin ack = 1'b1; rd = 8'(m_cnt / 256); end
  endfunction

  function automatic void model_edge();
    int spi_fall, mcu_rise, w1c, new_st, new_uf, tick, wd, mask;
    mask = TMR ? 7 : 5;
    wd   = int'(WriteData);
    if (Reset) begin
      m_en = 0; m_st = 0; m_nint = 1; m_spi_prev = 0; m_mcu_prev = 1;
      m_rel = 0; m_cnt = 0; m_pre = 0; m_run = 0; m_auto = 0; m_uf = 0;
      m_valid = 1'b1;
      return;
    end
    spi_fall = (m_spi_prev == 1 && SpiBusy == 1'b0) ? 1 : 0;
    mcu_rise = (m_mcu_prev == 0 && McuReq == 1'b1) ? 1 : 0;
    w1c      = (RegWrite && RegAddr == 8'hE7) ? (wd % 8) : 0;
    new_st   = ((m_st & ~w1c) | spi_fall | (m_uf * 2) | (mcu_rise * 4)) & mask;
    m_nint   = ((m_st & m_en) == 0) ? 1 : 0;
    m_st     = new_st;
    if (RegWrite && RegAddr == 8'hE6) m_en = wd & mask;
    new_uf = 0;
    if (TMR) begin
      tick  = (m_pre == 255) ? 1 : 0;
      m_pre = (m_pre + 1) % 256;
      if (RegWrite && RegAddr == 8'hEA) begin
        m_auto = (wd / 2) % 2;
        if (wd % 2 == 1) begin m_cnt = m_rel; m_pre = 0; m_run = 1; end
        else m_run = 0;
      end else if (m_run == 1 && tick == 1) begin
        if (m_cnt == 1) begin
          new_uf = 1;
          if (m_auto == 1) m_cnt = m_rel;
          else begin m_cnt = 0; m_run = 0; end
        end else begin
          m_cnt = (m_cnt + 65535) % 65536;
        end
      end
      if (RegWrite && RegAddr == 8'hE8) m_rel = (m_rel / 256) * 256 + wd;
      if (RegWrite && RegAddr == 8'hE9) m_rel = wd * 256 + (m_rel % 256);
    end
    m_uf       = new_uf;
    m_spi_prev = int'(SpiBusy);
    m_mcu_prev = int'(McuReq);
  endfunction

  // Issue one clock of stimulus: predict this cycle's outputs, then advance the model
  task automatic cycle();
    exp_t e;
    if (m_valid) begin
      m_read(RegAddr, e.ack, e.rd);
      e.nint = (m_nint != 0);
      e.cyc  = cyc;
      q.push_back(e);
    end
    @(posedge FastClk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    RegWrite = 1'b1; RegAddr = a; WriteData = d;
    cycle();
    RegWrite = 1'b0;
  endtask

  task automatic idle(input int n, input logic [7:0] a);
    RegAddr = a;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Park on a rotating set of registers while time passes
  task automatic run_rot(input int n);
    logic [7:0] rot [5];
    rot[0] = 8'hE7; rot[1] = 8'hEA; rot[2] = 8'hEB; rot[3] = 8'hEC; rot[4] = 8'hE8;
    for (int i = 0; i < n; i++) begin
      RegAddr = rot[i % 5];
      cycle();
    end
  endtask

  task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge FastClk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("regack", mon_e.cyc, {7'b0, RegAck}, {7'b0, mon_e.ack});
        if (mon_e.ack) chk("regout", mon_e.cyc, RegOut, mon_e.rd);
        chk("ncartint", mon_e.cyc, {7'b0, nCartInt}, {7'b0, mon_e.nint});
      end
    end
  end

  initial begin
    int guard;
    Reset = 1'b1;
    cycle();
    cycle();
    Reset = 1'b0;
    idle(2, 8'hE7);

    // SPI done with only bit0 enabled, then W1C release
    SpiBusy = 1'b1;
    wr(8'hE6, 8'h01);
    idle(3, 8'hE7);
    SpiBusy = 1'b0;
    idle(4, 8'hE7);
    wr(8'hE7, 8'h01);
    idle(3, 8'hE7);

    // MCU rising edge coinciding with a W1C of bit2
    wr(8'hE6, 8'h07);
    McuReq = 1'b1;
    idle(3, 8'hE7);
    McuReq = 1'b0;
    idle(2, 8'hE7);
    McuReq = 1'b1;
    wr(8'hE7, 8'h04);
    idle(3, 8'hE7);
    McuReq = 1'b0;
    wr(8'hE7, 8'h07);
    idle(2, 8'hE6);

    // Enable readback and timer-range ack
    wr(8'hE6, 8'h07);
    idle(2, 8'hE6);
    idle(2, 8'hE8);
    idle(2, 8'hEC);
    idle(2, 8'hED);
    idle(2, 8'hE5);

`ifdef CART_IRQ_TIMER_EN
    // One-shot: reload 3, underflow after ~768 cycles then IDLE with counter 0
    wr(8'hE6, 8'h02);
    wr(8'hE8, 8'h03);
    wr(8'hE9, 8'h00);
    wr(8'hEA, 8'h01);
    run_rot(800);
    wr(8'hE7, 8'h07);

    // Auto-reload every 512 cycles; mid-count reload change applies after next underflow
    wr(8'hE8, 8'h02);
    wr(8'hEA, 8'h03);
    run_rot(700);
    wr(8'hE8, 8'h05);
    run_rot(1700);
    wr(8'hEA, 8'h02);
    run_rot(20);

    // Reset at counter=1, prescaler=0xFE
    wr(8'hE8, 8'h01);
    wr(8'hE9, 8'h00);
    wr(8'hEA, 8'h01);
    guard = 0;
    while (m_pre != 254 && guard < 400) begin
      RegAddr = 8'hEB;
      cycle();
      guard++;
    end
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    run_rot(300);
    idle(2, 8'hE6);
    idle(2, 8'hE9);
`endif

    // Randomized traffic across the register window
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) SpiBusy = ~SpiBusy;
      if ($urandom_range(0, 4) == 0) McuReq = ~McuReq;
      RegAddr   = 8'hE4 + 8'($urandom_range(0, 11));
      RegWrite  = ($urandom_range(0, 5) == 0);
      WriteData = 8'($urandom);
      Reset     = ($urandom_range(0, 499) == 0);
      cycle();
    end
    RegWrite = 1'b0;
    Reset    = 1'b0;
    idle(3, 8'hE7);

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(negedge FastClk);
      guard++;
    end
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
